// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor with a start/done handshake.
// Computes a - b LSB first with one borrow flip-flop and reports borrow, zero and overflow.
module serial_sub #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   res;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           a_msb;
  logic           b_msb;

  logic           d_bit;
  logic           br_next;
  logic [N-1:0]   res_next;

  // One full-subtractor bit slice on the current LSBs.
  always_comb begin
    d_bit    = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next = {d_bit, res[N-1:1]};
  end

  // Control FSM, operand shifters and registered result/flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            a_msb <= a[N-1];
            b_msb <= b[N-1];
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[N-1:1]};
          sb  <= {1'b0, sb[N-1:1]};
          res <= res_next;
          br  <= br_next;
          // The last bit publishes the result; the counter is left at N-1 so it never wraps.
          if (cnt == CW'(N - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= br_next;
            zero   <= (res_next == {N{1'b0}});
            ovf    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end else begin
            cnt   <= cnt + CW'(1);
            state <= RUN;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and sweep bench for serial_sub at N=4, plus a random sweep at N=8.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       busy4, done4, borrow4, zero4, ovf4;
  logic       busy8, done8, borrow8, zero8, ovf8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_sub #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .zero(zero4), .ovf(ovf4)
  );

  serial_sub #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8), .ovf(ovf8)
  );

  // Reference: {diff, borrow, zero, ovf}
  function automatic logic [6:0] model4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] d;
    d = x - y;
    return {d, (x < y), (d == 4'h0), ((x[3] != y[3]) && (d[3] != x[3]))};
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
    return {d, (x < y), (d == 8'h00), ((x[7] != y[7]) && (d[7] != x[7]))};
  endfunction

  // Issue one N=4 operation; returns at the negedge where done is seen, lat = edges after acceptance.
  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, output int lat);
    @(negedge clk);
    a4 = ia; b4 = ib; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    a4 = ~ia; b4 = ib ^ 4'h5;
    lat = 0;
    while (done4 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL op4_timeout a=%h b=%h got done=%b want 1", ia, ib, done4);
    end
  endtask

  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, output int lat);
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~ia; b8 = ~ib;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++;
      $display("FAIL op8_timeout a=%h b=%h got done=%b want 1", ia, ib, done8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; a8 = 8'h00; b8 = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, diff4, borrow4, zero4, ovf4} !== 9'b0) begin
      errors++;
      $display("FAIL reset4 got %b want 0", {busy4, done4, diff4, borrow4, zero4, ovf4});
    end
    checks++;
    if ({busy8, done8, diff8, borrow8, zero8, ovf8} !== 13'b0) begin
      errors++;
      $display("FAIL reset8 got %b want 0", {busy8, done8, diff8, borrow8, zero8, ovf8});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int busy_cnt, done_cnt, done_at;
    logic [3:0] d_seen;
    logic [2:0] f_seen;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; d_seen = 4'h0; f_seen = 3'b000;
    for (int c = 0; c < 10; c++) begin
      if (busy4 === 1'b1) busy_cnt++;
      if (done4 === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          d_seen = diff4;
          f_seen = {borrow4, zero4, ovf4};
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done_at != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", done_at); end
    checks++;
    if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles got %0d want 5", busy_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    checks++;
    if (d_seen !== 4'h6) begin errors++; $display("FAIL basic_diff got %h want 6", d_seen); end
    // 9 is -7 signed; -7 - 3 overflows 4 bits
    checks++;
    if (f_seen !== 3'b001) begin errors++; $display("FAIL basic_flags got %b want 001", f_seen); end
    checks++;
    if (diff4 !== 4'h6) begin errors++; $display("FAIL basic_hold got %h want 6", diff4); end
  endtask

  task automatic test_vectors();
    logic [3:0] va [5] = '{4'h3, 4'h8, 4'h7, 4'h5, 4'h0};
    logic [3:0] vb [5] = '{4'h9, 4'h1, 4'hF, 4'h5, 4'h0};
    logic [3:0] vd [5] = '{4'hA, 4'h7, 4'h8, 4'h0, 4'h0};
    logic [2:0] vf [5] = '{3'b101, 3'b001, 3'b101, 3'b010, 3'b010};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op4(va[i], vb[i], lat);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL vec_latency[%0d] got %0d want 4", i, lat); end
      checks++;
      if (diff4 !== vd[i]) begin errors++; $display("FAIL vec_diff[%0d] got %h want %h", i, diff4, vd[i]); end
      checks++;
      if ({borrow4, zero4, ovf4} !== vf[i]) begin
        errors++;
        $display("FAIL vec_flags[%0d] got %b want %b", i, {borrow4, zero4, ovf4}, vf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pos [3] = '{5, 11, 17};
    logic [3:0] dv [3] = '{4'hF, 4'hB, 4'h7};
    int n_done;
    @(negedge clk);
    a4 = 4'(1); b4 = 4'(2); start4 = 1'b1;
    n_done = 0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        if (n_done < 3) begin
          checks++;
          if (c != pos[n_done] || diff4 !== dv[n_done]) begin
            errors++;
            $display("FAIL b2b_done[%0d] got cycle=%0d diff=%h want cycle=%0d diff=%h",
                     n_done, c, diff4, pos[n_done], dv[n_done]);
          end
        end
        n_done++;
      end
      if (c <= 12) begin
        a4 = 4'((c * 5 + 1) % 16);
        b4 = 4'((c * 3 + 2) % 16);
      end else begin
        start4 = 1'b0;
      end
    end
    checks++;
    if (n_done != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_done); end
  endtask

  task automatic test_reset_mid_run();
    int lat, seen;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy4, done4, diff4, borrow4, zero4, ovf4} !== 9'b0) begin
      errors++;
      $display("FAIL midrun_reset got %b want 0", {busy4, done4, diff4, borrow4, zero4, ovf4});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrun_no_done got %0d want 0", seen); end
    do_op4(4'hF, 4'h1, lat);
    checks++;
    if ({diff4, borrow4, zero4, ovf4} !== 7'b1110_000) begin
      errors++;
      $display("FAIL midrun_restart got %b want 1110000", {diff4, borrow4, zero4, ovf4});
    end
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [6:0] exp;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_op4(4'(x), 4'(y), lat);
        exp = model4(4'(x), 4'(y));
        checks++;
        if ({diff4, borrow4, zero4, ovf4} !== exp || lat != 4) begin
          errors++;
          $display("FAIL sweep4 a=%h b=%h got %b lat=%0d want %b lat=4",
                   x, y, {diff4, borrow4, zero4, ovf4}, lat, exp);
        end
      end
    end
  endtask

  task automatic test_random8();
    int lat;
    logic [7:0] x, y;
    logic [10:0] exp;
    for (int i = 0; i < 150; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if (i == 0) begin x = 8'h80; y = 8'h01; end
      if (i == 1) begin x = 8'h7F; y = 8'hFF; end
      do_op8(x, y, lat);
      exp = model8(x, y);
      checks++;
      if ({diff8, borrow8, zero8, ovf8} !== exp || lat != 8) begin
        errors++;
        $display("FAIL sweep8 a=%h b=%h got %b lat=%0d want %b lat=8",
                 x, y, {diff8, borrow8, zero8, ovf8}, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive4();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
